rle_stream_scheduler: RTL



---
 rtl/rle_stream_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rle_stream_scheduler.sv
// Frame scheduler: emits a header word, then shares one RLE output link among
// N_REQ run-word streams round-robin, one whole line per grant, until each stream has sent FRAME_H lines.
module rle_stream_scheduler #(
  parameter int                N_REQ    = 3,
  parameter int                WORD_W   = 11,
  parameter int                FRAME_H  = 480,
  parameter logic [WORD_W-1:0] HDR_WORD = {WORD_W{1'b1}}
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [WORD_W-1:0]         out_data,
  output logic [1:0]                out_src,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int               CNT_W     = $clog2(FRAME_H + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_H);
  localparam logic [1:0]       HDR_SRC   = 2'(N_REQ);
  localparam logic [1:0]       LAST_INIT = 2'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, HEADER, ARB, XFER, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         grant, last_grant;
  logic [CNT_W-1:0]   line_cnt [N_REQ];
  logic [N_REQ-1:0]   eligible;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               sel_valid, sel_last;
  logic [WORD_W-1:0]  sel_data;
  logic               line_end, all_done;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (line_cnt[i] < CNT_MAX);
    end
  end

  // Round-robin: first look above last_grant, then wrap around to the bottom.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && eligible[i] && (2'(i) > last_grant)) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && eligible[i] && (2'(i) <= last_grant)) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 2'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  assign line_end = (state == XFER) && sel_valid && out_ready && sel_last;

  // Frame is complete when the granted stream's count after this line closes the set.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 2'(i)) begin
        if (line_cnt[i] + CNT_W'(1) != CNT_MAX) all_done = 1'b0;
      end else if (line_cnt[i] != CNT_MAX) begin
        all_done = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_src    = 2'd0;
    out_last   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = HEADER;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_data  = HDR_WORD;
        out_src   = HDR_SRC;
        out_last  = 1'b1;
        if (out_ready) state_nxt = ARB;
      end
      ARB: begin
        if (pick_found) state_nxt = XFER;
      end
      XFER: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        out_last  = sel_last;
        out_src   = grant;
        for (int i = 0; i < N_REQ; i++) begin
          req_ready[i] = (grant == 2'(i)) && out_ready;
        end
        if (line_end) state_nxt = all_done ? DONE : ARB;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= LAST_INIT;
      overrun    <= 1'b0;
      for (int i = 0; i < N_REQ; i++) line_cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start && (state != IDLE)) overrun <= 1'b1;
      if ((state == ARB) && pick_found) begin
        grant      <= pick_idx;
        last_grant <= pick_idx;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if ((state == IDLE) && frame_start) begin
          line_cnt[i] <= '0;
        end else if (line_end && (grant == 2'(i))) begin
          line_cnt[i] <= line_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule
